// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce filter.
package debounce_pkg;

    // Default synchronizer depth on the raw input.
    localparam int unsigned SYNC_STAGES_DEF   = 2;
    // Default number of consecutive synchronized cycles needed to accept a new level.
    localparam int unsigned STABLE_CYCLES_DEF = 16;

    // Filter states: two settled levels plus a qualification state for each direction.
    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    // Debounced level presented while in a given state.
    function automatic logic level_of(input state_t s);
        return (s == S_HIGH) || (s == S_FALL_CHK);
    endfunction

    // True while a candidate level change is being qualified.
    function automatic logic is_check(input state_t s);
        return (s == S_RISE_CHK) || (s == S_FALL_CHK);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_chain: DEPTH must be at least 2");
    end

    logic [DEPTH-1:0] stages;

    // Shift the raw level through the chain; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter: synchronizes a bouncing input and only accepts a new level
// once it has been seen for STABLE_CYCLES consecutive synchronized cycles.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_filter: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_filter: STABLE_CYCLES must be at least 2");
    end

    localparam int unsigned    CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             din_s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_dout;
    logic             next_rise;
    logic             next_fall;
    logic             next_busy;

    // Only the synchronized level is used past this point.
    sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    // Next-state, qualification counter and next output values.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        next_rise  = 1'b0;
        next_fall  = 1'b0;

        case (state)
            S_LOW: begin
                if (din_s) begin
                    next_state = S_RISE_CHK;
                    next_cnt   = CNT_ONE;
                end
            end
            S_RISE_CHK: begin
                if (!din_s) begin
                    next_state = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    next_state = S_HIGH;
                    next_rise  = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!din_s) begin
                    next_state = S_FALL_CHK;
                    next_cnt   = CNT_ONE;
                end
            end
            S_FALL_CHK: begin
                if (din_s) begin
                    next_state = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    next_state = S_LOW;
                    next_fall  = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = S_LOW;
            end
        endcase

        next_dout = level_of(next_state);
        next_busy = is_check(next_state);
    end

    // State, counter and registered outputs; reset forces everything low at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOW;
            cnt        <= '0;
            dout       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            dout       <= next_dout;
            rise_pulse <= next_rise;
            fall_pulse <= next_fall;
            busy       <= next_busy;
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter at default parameters.
module tb_debounce_filter;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 16;

    logic clk;
    logic rst;
    logic din;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    debounce_filter #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } obs_t;

    typedef struct {
        logic din;
        int   cycles;
        logic exp_dout;
        logic exp_busy;
        int   exp_rise;
        int   exp_fall;
    } vec_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: run-length of synchronized samples disagreeing with the output.
    logic [SYNC-1:0] m_sync;
    logic            m_dout;
    int              m_run;

    int   edge_idx;
    int   rise_cnt;
    int   fall_cnt;
    int   first_rise_edge;
    int   first_fall_edge;
    int   first_busy_edge;
    logic prev_pulse;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t edge=%0d: got %b expected %b", name, $time, edge_idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic clear_counters();
        edge_idx        = 0;
        rise_cnt        = 0;
        fall_cnt        = 0;
        first_rise_edge = -1;
        first_fall_edge = -1;
        first_busy_edge = -1;
        prev_pulse      = 1'b0;
    endtask

    task automatic model_reset();
        m_sync = '0;
        m_dout = 1'b0;
        m_run  = 0;
    endtask

    task automatic model_edge(input logic d, output obs_t e);
        logic ds;
        ds = m_sync[SYNC-1];
        e  = '0;
        m_sync = {m_sync[SYNC-2:0], d};
        if (ds != m_dout) begin
            m_run++;
            if (m_run == STABLE) begin
                m_dout = ~m_dout;
                m_run  = 0;
                if (m_dout) e.rise = 1'b1;
                else        e.fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        e.dout = m_dout;
        e.busy = (m_run != 0);
    endtask

    // Drive one input value (called just after a rising edge) and check the next edge.
    task automatic step(input logic d);
        obs_t e;
        obs_t a;
        din = d;
        model_edge(d, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        edge_idx++;
        a = {dout, rise_pulse, fall_pulse, busy};
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            check_bit("dout", a.dout, e.dout);
            check_bit("rise_pulse", a.rise, e.rise);
            check_bit("fall_pulse", a.fall, e.fall);
            check_bit("busy", a.busy, e.busy);
        end
        check_bit("pulse_overlap", rise_pulse & fall_pulse, 1'b0);
        check_bit("pulse_back_to_back", prev_pulse & (rise_pulse | fall_pulse), 1'b0);
        prev_pulse = rise_pulse | fall_pulse;
        if (rise_pulse) begin
            rise_cnt++;
            if (first_rise_edge < 0) first_rise_edge = edge_idx;
        end
        if (fall_pulse) begin
            fall_cnt++;
            if (first_fall_edge < 0) first_fall_edge = edge_idx;
        end
        if (busy && first_busy_edge < 0) first_busy_edge = edge_idx;
    endtask

    // Assert reset between edges, confirm outputs clear before the next edge, release between edges.
    task automatic apply_reset(input logic d_during);
        #3;
        rst = 1'b1;
        din = d_during;
        #1;
        check_bit("rst_dout", dout, 1'b0);
        check_bit("rst_rise", rise_pulse, 1'b0);
        check_bit("rst_fall", fall_pulse, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_counters();
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b0, 50, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{1'b1, 15, 1'b0, 1'b1, 0, 0};
        vecs[2]  = '{1'b0, 20, 1'b0, 1'b0, 0, 0};
        vecs[3]  = '{1'b1, 16, 1'b0, 1'b1, 0, 0};
        vecs[4]  = '{1'b0,  2, 1'b1, 1'b0, 1, 0};
        vecs[5]  = '{1'b1, 30, 1'b1, 1'b0, 0, 0};
        vecs[6]  = '{1'b0,  3, 1'b1, 1'b1, 0, 0};
        vecs[7]  = '{1'b1,  3, 1'b1, 1'b0, 0, 0};
        vecs[8]  = '{1'b0,  3, 1'b1, 1'b1, 0, 0};
        vecs[9]  = '{1'b1,  3, 1'b1, 1'b0, 0, 0};
        vecs[10] = '{1'b0,  3, 1'b1, 1'b1, 0, 0};
        vecs[11] = '{1'b1,  3, 1'b1, 1'b0, 0, 0};
        vecs[12] = '{1'b0, 40, 1'b0, 1'b0, 0, 1};

        rst = 1'b0;
        din = 1'b0;
        clear_counters();
        model_reset();
        @(posedge clk);
        #1;
        apply_reset(1'b0);

        // Phase table: quiet input, short/exact pulses, aborts and a bouncing release.
        for (int v = 0; v < 13; v++) begin
            clear_counters();
            for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].din);
            check_bit($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
            check_bit($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
            check_int($sformatf("vec%0d_rises", v), rise_cnt, vecs[v].exp_rise);
            check_int($sformatf("vec%0d_falls", v), fall_cnt, vecs[v].exp_fall);
            if (v == 12) check_int("bounce_fall_edge", first_fall_edge, 18);
        end

        // Clean 0->1 step: busy from edge 3, rise on edge 18, dout held afterwards.
        clear_counters();
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            if (edge_idx >= 18) check_bit("step_dout_held", dout, 1'b1);
        end
        check_int("step_busy_edge", first_busy_edge, 3);
        check_int("step_rise_edge", first_rise_edge, 18);
        check_int("step_rise_count", rise_cnt, 1);
        clear_counters();
        for (int c = 0; c < 30; c++) step(1'b0);
        check_int("step_fall_edge", first_fall_edge, 18);
        check_bit("step_low_dout", dout, 1'b0);

        // Reset in the middle of a rising check (counter at 8).
        clear_counters();
        for (int c = 0; c < 10; c++) step(1'b1);
        check_bit("midchk_busy", busy, 1'b1);
        apply_reset(1'b0);
        for (int c = 0; c < 40; c++) step(1'b0);
        check_int("midchk_no_rise", rise_cnt, 0);
        check_bit("midchk_dout", dout, 1'b0);

        // Input held high through reset release behaves as a fresh rise.
        apply_reset(1'b1);
        for (int c = 0; c < 40; c++) step(1'b1);
        check_int("release_rise_edge", first_rise_edge, 18);
        check_int("release_rise_count", rise_cnt, 1);
        check_bit("release_dout", dout, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on din.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 16: consecutive synchronized cycles required to accept a new level.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port din, input, 1 bit: asynchronous, possibly bouncing raw level.
REQ-006 The block SHALL have port dout, output, 1 bit: debounced, synchronized level.
REQ-007 The block SHALL have port rise_pulse, output, 1 bit: one-cycle strobe when dout goes 0->1.
REQ-008 The block SHALL have port fall_pulse, output, 1 bit: one-cycle strobe when dout goes 1->0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 din SHALL pass through a SYNC_STAGES-deep flop chain; only the final stage (din_s) SHALL feed any further logic.
REQ-011 The FSM SHALL have exactly four states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK.
REQ-012 S_LOW: din_s=1 -> S_RISE_CHK with counter=1; otherwise stay, counter=0.
REQ-013 S_RISE_CHK: din_s=0 -> S_LOW, counter=0; din_s=1 and counter=STABLE_CYCLES-1 -> S_HIGH, counter=0; otherwise counter+1.
REQ-014 S_HIGH and S_FALL_CHK SHALL mirror S_LOW and S_RISE_CHK with din_s polarity inverted.
REQ-015 dout SHALL be a registered output: 1 in S_HIGH/S_FALL_CHK, 0 in S_LOW/S_RISE_CHK.
REQ-016 rise_pulse SHALL be registered, high for exactly the one cycle after the S_RISE_CHK->S_HIGH edge, coincident with dout's first cycle at 1; fall_pulse likewise for S_FALL_CHK->S_LOW.
REQ-017 rise_pulse and fall_pulse SHALL never be high in the same cycle, and SHALL never be high on consecutive cycles.
REQ-018 busy SHALL be registered, high exactly while the state is S_RISE_CHK or S_FALL_CHK.
REQ-019 Latency: din changes and then holds -> dout updates on exactly the (SYNC_STAGES+STABLE_CYCLES)-th rising edge after the first edge that samples the new level (18 at defaults).
REQ-020 Any din_s return to the current dout level during a check SHALL abort it with no output change; the next qualification restarts from counter=1.
REQ-021 Counter width SHALL be $clog2(STABLE_CYCLES+1); the counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-022 SYNC_STAGES<2 or STABLE_CYCLES<2 SHALL cause an elaboration-time error.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for a clock edge, force: all sync flops 0, state S_LOW, counter 0, dout 0, rise_pulse 0, fall_pulse 0, busy 0.
REQ-024 rst asserted mid-check SHALL discard the check; no pulse SHALL be emitted for it.
REQ-025 After rst deasserts with din=1, the block SHALL behave as a 0->1 change: rise_pulse fires per REQ-019.

Structure
REQ-026 Package debounce_pkg SHALL hold the state enum type and the default constants for SYNC_STAGES and STABLE_CYCLES.
REQ-027 The synchronizer SHALL be a separate sub-module sync_chain (parameterized depth, async active-high reset to 0), instantiated once.
REQ-028 The FSM, counter and output registers SHALL reside in debounce_filter; no latches; no combinational path from din to any output.

Verification
REQ-029 Bench: reset, din=0 for 50 cycles -> dout=0, busy=0, no pulses.
REQ-030 Bench: din 0->1 held -> busy rises; rise_pulse high one cycle on edge 18; dout=1 from that edge on.
REQ-031 Bench: din=1 for 15 cycles then 0 -> busy pulses, dout stays 0, no rise_pulse. Bench: din=1 for exactly 16 cycles -> rise_pulse fires once.
REQ-032 Bench: from dout=1, din bounces 1->0->1 three times at 3-cycle spacing, then holds 0 -> exactly one fall_pulse, 18 edges after the final falling transition.
REQ-033 Bench: rst asserted at counter=8 in S_RISE_CHK, between clock edges -> all outputs 0 before the next edge; no rise_pulse afterwards while din=0.
REQ-034 Bench: din held 1 through reset release -> rise_pulse on edge 18 after release.
